// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_stage_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_sel;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_sel, dm_wdata,
      input  dm_ack, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_sel, dm_wdata,
      output dm_ack, dm_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: ALU pass-through, big-endian loads/stores over a
// req/ack data-memory bus, alignment checking and bus-timeout abort.
module mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ex_dest_addr,
   input  logic        ex_wreg,
   input  logic [31:0] ex_dest_data,
   input  logic [3:0]  ex_mem_op,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_store_data,
   output logic [4:0]  mem_dest_addr,
   output logic        mem_wreg,
   output logic [31:0] mem_dest_data,
   mem_stage_if.master dm,
   output logic        stallreq,
   output logic        align_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   localparam logic [7:0] TcntLast = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  tcnt_q, tcnt_d;
   logic        abort_q, abort_d;
   logic [31:0] rdata_q, rdata_d;

   logic        is_load, is_store, is_signed, is_mem, misaligned;
   logic [1:0]  size; // 0 byte, 1 halfword, 2 word
   logic [3:0]  lane_sel;
   logic [31:0] lane_wdata, load_data;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Decode the memory op into direction, access size and signedness.
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_signed = 1'b0;
      size      = 2'd2;
      case (ex_mem_op)
         4'd1: begin is_load  = 1'b1; is_signed = 1'b1; size = 2'd0; end
         4'd2: begin is_load  = 1'b1; size = 2'd0; end
         4'd3: begin is_load  = 1'b1; is_signed = 1'b1; size = 2'd1; end
         4'd4: begin is_load  = 1'b1; size = 2'd1; end
         4'd5: begin is_load  = 1'b1; size = 2'd2; end
         4'd6: begin is_store = 1'b1; size = 2'd0; end
         4'd7: begin is_store = 1'b1; size = 2'd1; end
         4'd8: begin is_store = 1'b1; size = 2'd2; end
         default: ;
      endcase
      is_mem     = is_load | is_store;
      misaligned = is_mem && ((size == 2'd1 && ex_mem_addr[0]) ||
                              (size == 2'd2 && ex_mem_addr[1:0] != 2'b00));
   end

   // Big-endian lane select, store replication and load extraction from rdata_q.
   always_comb begin
      lane_sel   = 4'b1111;
      lane_wdata = ex_store_data;
      load_data  = rdata_q;
      byte_v     = 8'h00;
      half_v     = 16'h0000;
      case (size)
         2'd0: begin
            lane_sel   = 4'b1000 >> ex_mem_addr[1:0];
            lane_wdata = {4{ex_store_data[7:0]}};
            case (ex_mem_addr[1:0])
               2'd0:    byte_v = rdata_q[31:24];
               2'd1:    byte_v = rdata_q[23:16];
               2'd2:    byte_v = rdata_q[15:8];
               default: byte_v = rdata_q[7:0];
            endcase
            load_data = is_signed ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
         end
         2'd1: begin
            lane_sel   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
            lane_wdata = {2{ex_store_data[15:0]}};
            half_v     = ex_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
            load_data  = is_signed ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
         end
         default: ;
      endcase
   end

   // Next-state logic and all outputs; reset forces every output low.
   always_comb begin
      state_d       = state_q;
      tcnt_d        = tcnt_q;
      abort_d       = abort_q;
      rdata_d       = rdata_q;
      mem_dest_addr = 5'd0;
      mem_wreg      = 1'b0;
      mem_dest_data = 32'h0;
      dm.dm_req     = 1'b0;
      dm.dm_we      = 1'b0;
      dm.dm_addr    = 32'h0;
      dm.dm_sel     = 4'h0;
      dm.dm_wdata   = 32'h0;
      stallreq      = 1'b0;
      align_err     = 1'b0;
      bus_err       = 1'b0;
      if (rst) begin
         mem_dest_addr = ex_dest_addr;
         mem_dest_data = ex_dest_data;
         mem_wreg      = ex_wreg;
         align_err     = misaligned;
         unique case (state_q)
            StIdle: begin
               if (misaligned) begin
                  mem_wreg = 1'b0;
               end else if (is_mem) begin
                  dm.dm_req   = 1'b1;
                  dm.dm_we    = is_store;
                  dm.dm_addr  = {ex_mem_addr[31:2], 2'b00};
                  dm.dm_sel   = lane_sel;
                  dm.dm_wdata = is_store ? lane_wdata : 32'h0;
                  stallreq    = 1'b1;
                  mem_wreg    = 1'b0;
                  tcnt_d      = 8'd0;
                  if (dm.dm_ack) begin
                     rdata_d = dm.dm_rdata;
                     state_d = StDone;
                  end else begin
                     state_d = StWait;
                  end
               end
            end
            StWait: begin
               dm.dm_req   = 1'b1;
               dm.dm_we    = is_store;
               dm.dm_addr  = {ex_mem_addr[31:2], 2'b00};
               dm.dm_sel   = lane_sel;
               dm.dm_wdata = is_store ? lane_wdata : 32'h0;
               stallreq    = 1'b1;
               mem_wreg    = 1'b0;
               tcnt_d      = tcnt_q + 8'd1;
               // An ack on the final wait cycle still completes the access.
               if (dm.dm_ack) begin
                  rdata_d = dm.dm_rdata;
                  state_d = StDone;
               end else if (tcnt_q == TcntLast) begin
                  abort_d = 1'b1;
                  state_d = StDone;
               end
            end
            StDone: begin
               if (is_load) begin
                  mem_dest_data = load_data;
               end else begin
                  mem_wreg = 1'b0;
               end
               if (abort_q) begin
                  mem_wreg = 1'b0;
                  bus_err  = 1'b1;
               end
               abort_d = 1'b0;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         tcnt_q  <= 8'd0;
         abort_q <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         abort_q <= abort_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage (TIMEOUT = 4).
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ex_dest_addr;
   logic        ex_wreg;
   logic [31:0] ex_dest_data;
   logic [3:0]  ex_mem_op;
   logic [31:0] ex_mem_addr;
   logic [31:0] ex_store_data;
   logic [4:0]  mem_dest_addr;
   logic        mem_wreg;
   logic [31:0] mem_dest_data;
   logic        stallreq, align_err, bus_err;

   mem_stage_if bus ();

   mem_stage #(.TIMEOUT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_dest_addr  (ex_dest_addr),
      .ex_wreg       (ex_wreg),
      .ex_dest_data  (ex_dest_data),
      .ex_mem_op     (ex_mem_op),
      .ex_mem_addr   (ex_mem_addr),
      .ex_store_data (ex_store_data),
      .mem_dest_addr (mem_dest_addr),
      .mem_wreg      (mem_wreg),
      .mem_dest_data (mem_dest_data),
      .dm            (bus),
      .stallreq      (stallreq),
      .align_err     (align_err),
      .bus_err       (bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] ddata;
      logic [4:0]  dest;
      logic        wreg;
      logic [31:0] rdata;
      int          ack_at; // stall-cycle index carrying dm_ack, -1 for none
   } stim_t;

   typedef struct {
      int          stall;
      logic        align;
      logic        req;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic        wreg;
      logic        chk_data;
      logic [31:0] data;
      logic        berr;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] load_model(input logic [3:0] op, input logic [1:0] a,
                                              input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8 * (3 - int'(a)) +: 8];
      h = a[1] ? w[15:0] : w[31:16];
      case (op)
         4'd1:    return {{24{b[7]}}, b};
         4'd2:    return {24'h0, b};
         4'd3:    return {{16{h[15]}}, h};
         4'd4:    return {16'h0, h};
         default: return w;
      endcase
   endfunction

   task automatic run(input stim_t s, input exp_t e);
      exp_t x;
      int   cyc;
      @(negedge clk);
      ex_mem_op     = s.op;
      ex_mem_addr   = s.addr;
      ex_store_data = s.sdata;
      ex_dest_data  = s.ddata;
      ex_dest_addr  = s.dest;
      ex_wreg       = s.wreg;
      bus.dm_rdata  = s.rdata;
      bus.dm_ack    = 1'b0;
      exp_q.push_back(e);
      cyc = 0;
      #1;
      check({s.tag, ".align"}, 32'(align_err), 32'(exp_q[0].align));
      check({s.tag, ".req"}, 32'(bus.dm_req), 32'(exp_q[0].req));
      check({s.tag, ".berr_idle"}, 32'(bus_err), 32'(0));
      if (bus.dm_req) begin
         check({s.tag, ".we"}, 32'(bus.dm_we), 32'(exp_q[0].we));
         check({s.tag, ".sel"}, 32'(bus.dm_sel), 32'(exp_q[0].sel));
         check({s.tag, ".wdata"}, bus.dm_wdata, exp_q[0].wdata);
         check({s.tag, ".addr"}, bus.dm_addr, {s.addr[31:2], 2'b00});
      end
      while (stallreq && cyc < 64) begin
         bus.dm_ack = (cyc == s.ack_at);
         @(negedge clk);
         bus.dm_ack = 1'b0;
         cyc++;
         #1;
      end
      x = exp_q.pop_front();
      check({s.tag, ".stall_cycles"}, 32'(cyc), 32'(x.stall));
      check({s.tag, ".stall_done"}, 32'(stallreq), 32'(0));
      check({s.tag, ".req_done"}, 32'(bus.dm_req), 32'(0));
      check({s.tag, ".wreg"}, 32'(mem_wreg), 32'(x.wreg));
      check({s.tag, ".berr"}, 32'(bus_err), 32'(x.berr));
      check({s.tag, ".dest"}, 32'(mem_dest_addr), 32'(s.dest));
      if (x.chk_data) check({s.tag, ".data"}, mem_dest_data, x.data);
   endtask

   stim_t s;
   exp_t  e;

   initial begin
      rst           = 1'b0;
      ex_dest_addr  = 5'd9;
      ex_wreg       = 1'b1;
      ex_dest_data  = 32'hDEAD_BEEF;
      ex_mem_op     = 4'd5;
      ex_mem_addr   = 32'h103;
      ex_store_data = 32'h0;
      bus.dm_ack    = 1'b0;
      bus.dm_rdata  = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      check("rst.wreg", 32'(mem_wreg), 32'(0));
      check("rst.data", mem_dest_data, 32'h0);
      check("rst.dest", 32'(mem_dest_addr), 32'(0));
      check("rst.align", 32'(align_err), 32'(0));
      check("rst.req", 32'(bus.dm_req), 32'(0));
      check("rst.stall", 32'(stallreq), 32'(0));
      @(negedge clk);
      rst       = 1'b1;
      ex_mem_op = 4'd0;

      // ALU pass-through
      s = '{"add", 4'd0, 32'h0, 32'h0, 32'h1234, 5'd3, 1'b1, 32'h0, -1};
      e = '{0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h1234, 1'b0};
      run(s, e);
      // LB / LBU, ack in the request cycle
      s = '{"lb", 4'd1, 32'h101, 32'h0, 32'h0, 5'd4, 1'b1, 32'h00F0_0000, 0};
      e = '{1, 1'b0, 1'b1, 1'b0, 4'b0100, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0};
      run(s, e);
      s.tag = "lbu"; s.op = 4'd2;
      e.data = 32'h0000_00F0;
      run(s, e);
      // SH, ack on the second wait cycle
      s = '{"sh", 4'd7, 32'h202, 32'hABCD, 32'h0, 5'd5, 1'b1, 32'h0, 2};
      e = '{3, 1'b0, 1'b1, 1'b1, 4'b0011, 32'hABCD_ABCD, 1'b0, 1'b0, 32'h0, 1'b0};
      run(s, e);
      // misaligned LW
      s = '{"lw_mis", 4'd5, 32'h103, 32'h0, 32'h55, 5'd6, 1'b1, 32'h0, -1};
      e = '{0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      run(s, e);
      // LW timeout, then ack on the last wait cycle
      s = '{"lw_to", 4'd5, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 32'h1122_3344, -1};
      e = '{5, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1};
      run(s, e);
      s.tag = "lw_late"; s.ack_at = 4;
      e = '{5, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 32'h1122_3344, 1'b0};
      run(s, e);
      // more lane patterns
      s = '{"lh", 4'd3, 32'h2, 32'h0, 32'h0, 5'd8, 1'b1, 32'h1234_8765, 1};
      e = '{2, 1'b0, 1'b1, 1'b0, 4'b0011, 32'h0, 1'b1, 1'b1,
            load_model(4'd3, 2'd2, 32'h1234_8765), 1'b0};
      run(s, e);
      s = '{"lhu", 4'd4, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1, 32'h9234_8765, 0};
      e = '{1, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h0, 1'b1, 1'b1,
            load_model(4'd4, 2'd0, 32'h9234_8765), 1'b0};
      run(s, e);
      s = '{"lb3", 4'd1, 32'h7, 32'h0, 32'h0, 5'd2, 1'b0, 32'h0000_0080, 0};
      e = '{1, 1'b0, 1'b1, 1'b0, 4'b0001, 32'h0, 1'b0, 1'b1,
            load_model(4'd1, 2'd3, 32'h0000_0080), 1'b0};
      run(s, e);
      s = '{"sb", 4'd6, 32'h3, 32'h1234_565A, 32'h0, 5'd1, 1'b1, 32'h0, 0};
      e = '{1, 1'b0, 1'b1, 1'b1, 4'b0001, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0, 1'b0};
      run(s, e);
      s = '{"sw", 4'd8, 32'h8, 32'hCAFE_F00D, 32'h0, 5'd1, 1'b1, 32'h0, 1};
      e = '{2, 1'b0, 1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b0};
      run(s, e);

      // reset while waiting for an ack
      @(negedge clk);
      ex_mem_op   = 4'd5;
      ex_mem_addr = 32'h40;
      ex_wreg     = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rwait.stall_before", 32'(stallreq), 32'(1));
      rst = 1'b0;
      #1;
      check("rwait.req", 32'(bus.dm_req), 32'(0));
      check("rwait.stall", 32'(stallreq), 32'(0));
      check("rwait.sel", 32'(bus.dm_sel), 32'(0));
      check("rwait.wreg", 32'(mem_wreg), 32'(0));
      @(negedge clk);
      rst          = 1'b1;
      ex_mem_op    = 4'd0;
      ex_dest_data = 32'hCAFE;
      bus.dm_ack   = 1'b1;
      #1;
      check("rwait.idle_stall", 32'(stallreq), 32'(0));
      check("rwait.idle_req", 32'(bus.dm_req), 32'(0));
      check("rwait.pass_wreg", 32'(mem_wreg), 32'(1));
      check("rwait.pass_data", mem_dest_data, 32'hCAFE);
      @(negedge clk);
      bus.dm_ack = 1'b0;
      #1;
      check("rwait.after_berr", 32'(bus_err), 32'(0));
      check("rwait.after_stall", 32'(stallreq), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS32 memory-access stage, between the EX/MEM pipeline register and the MEM/WB register.
- Passes ALU results through unchanged.
- Executes loads and stores over a request/acknowledge data-memory port, including byte-lane selection, sign or zero extension and alignment checks.
- Holds the pipeline with stallreq while a transaction is outstanding.
- Aborts a transaction on a bus timeout.

Parameters:
- TIMEOUT, 16: number of WAIT cycles without dm_ack before the access is aborted; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- ex_dest_addr  in  5  destination register from EX/MEM.
- ex_wreg  in  1  register-write enable from EX/MEM.
- ex_dest_data  in  32  ALU result.
- ex_mem_op  in  4  memory op: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
- ex_mem_addr  in  32  effective byte address.
- ex_store_data  in  32  rt value to be stored.
- mem_dest_addr  out  5  to MEM/WB.
- mem_wreg  out  1  to MEM/WB.
- mem_dest_data  out  32  to MEM/WB.
- dm_req  out  1  memory request; held high until acknowledged.
- dm_we  out  1  1 = write.
- dm_addr  out  32  {ex_mem_addr[31:2], 2'b00}.
- dm_sel  out  4  byte-lane enables, big-endian.
- dm_wdata  out  32  store data replicated across the byte lanes.
- dm_ack  in  1  single-cycle acknowledge; dm_rdata is valid in the same cycle.
- dm_rdata  in  32  read word.
- stallreq  out  1  asks the pipeline to hold EX/MEM and earlier stages.
- align_err  out  1  misaligned access (combinational).
- bus_err  out  1  one-cycle pulse in DONE after a timeout abort.

Behaviour:
- States: IDLE, WAIT, DONE.
- Internal registers: rdata_q (32 bits), tcnt (8 bits), abort_q (1 bit).
- Reset:
  - While rst = 0, every output is driven to 0.
  - On the edge: state <= IDLE, tcnt <= 0, abort_q <= 0, rdata_q <= 0.
  - Reset while in WAIT drops dm_req in the cycle rst is low. A late dm_ack after reset is ignored.
- Byte lanes (big-endian):
  - Byte at addr[1:0] = 0/1/2/3 uses sel 1000/0100/0010/0001, data [31:24]/[23:16]/[15:8]/[7:0].
  - Halfword at addr[1] = 0/1 uses sel 1100/0011.
  - Word uses sel 1111.
- Store data: SB sends {4{b}}, SH sends {2{h}}, SW sends the word as is.
- Alignment:
  - LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0, sets align_err = 1.
  - In that case: no request, mem_wreg = 0, stallreq = 0, state stays IDLE.
- Non-memory op (IDLE): outputs pass through in zero cycles; mem_dest_data = ex_dest_data, mem_wreg = ex_wreg, stallreq = 0.
- IDLE with an aligned memory op:
  - dm_req = 1, stallreq = 1, tcnt <= 0.
  - dm_ack = 1: capture rdata_q <= dm_rdata, go to DONE.
  - Otherwise go to WAIT.
- WAIT:
  - dm_req = 1, stallreq = 1, tcnt increments each cycle.
  - dm_ack = 1: capture rdata, go to DONE.
  - Else, if tcnt = TIMEOUT-1: abort_q <= 1, go to DONE.
  - dm_ack on the timeout cycle wins: the transaction completes normally.
- DONE:
  - dm_req = 0, stallreq = 0.
  - Load result is rdata_q lane-extracted: LB/LH sign-extended, LBU/LHU zero-extended.
  - Stores force mem_wreg = 0 whatever ex_wreg is.
  - If abort_q = 1: mem_wreg = 0, bus_err = 1.
  - Next state is IDLE, abort_q <= 0. The pipeline advances on this edge.
- Latency: a zero-wait load stalls 1 cycle; an ack after k WAIT cycles stalls k+1 cycles.
- dm_we, dm_addr, dm_sel, dm_wdata are valid whenever dm_req = 1, and 0 otherwise.
- mem_dest_addr = ex_dest_addr in all non-reset cycles.

Test Plan:
- ADD result: op 0, dest 5'd3, data 32'h1234, wreg 1 -> same cycle mem_wreg = 1, mem_dest_data = 32'h1234, stallreq = 0, dm_req = 0.
- LB addr 32'h101, ack same cycle with rdata 32'h00F0_0000 -> IDLE stall = 1, sel 0100; DONE mem_dest_data = 32'hFFFF_FFF0, wreg = 1. Repeat with LBU -> 32'h0000_00F0.
- SH addr 32'h202, store 32'hABCD, ex_wreg 1, ack after 2 WAIT cycles -> dm_we = 1, sel 0011, wdata 32'hABCD_ABCD, stallreq high for 3 cycles, DONE mem_wreg = 0.
- LW addr 32'h103 -> align_err = 1, dm_req = 0, mem_wreg = 0, stallreq = 0.
- TIMEOUT = 4, LW with no ack -> 4 WAIT cycles, then DONE with bus_err = 1 and mem_wreg = 0, IDLE next; ack on the 4th WAIT cycle instead -> normal completion, bus_err = 0.
- rst low during WAIT -> in that cycle dm_req = 0, stallreq = 0, all outputs 0; next cycle state IDLE; ack arriving after reset has no effect.
